// File: rtl/uart_cpu_link.sv
// uart_cpu_link - host-link controller that single-steps a CPU over a UART byte stream.
//
// The host talks to this block through the UART rx/tx byte engines using a
// valid/ready byte handshake. Commands: 0x01 reboot the link (pulses cpu_reset),
// 0x02 read back the PC, 0x03 load one instruction and step the CPU once. Any
// memory access raised by the stepped instruction is proxied to the host:
// address, size code and store data are sent out, and load data is received back.
// Multi-byte fields travel little-endian, width/8 bytes each.
//
// Optional feature (macro UART_CPU_LINK_TIMEOUT_EN): a host-silence counter in the
// two receive states aborts to a NAK after TIMEOUT_CYC idle cycles.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-low reset
//   rx_data/rx_valid/rx_ready  byte stream from the UART receiver
//   tx_data/tx_valid/tx_ready  byte stream to the UART transmitter
//   pc                         CPU program counter (sent on command 0x02)
//   cpu_reset, cpu_run         one-cycle CPU reset / step pulses
//   instr                      instruction for the step, held between steps
//   write_enable, read_enable  CPU memory request flags, sampled in RUN
//   address, write_data        CPU memory request address / store data
//   mem_write, size_load       store / load size codes
//   read_data                  load data returned by the host, held until next load
//   busy                       low only while waiting for a command
module uart_cpu_link #(
  parameter int         XLEN        = 32,
  parameter int         ILEN        = 32,
  parameter logic [7:0] READY_BYTE  = 8'h01,
  parameter logic [7:0] NAK_BYTE    = 8'hEE,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  input  logic [XLEN-1:0] pc,
  output logic            cpu_reset,
  output logic            cpu_run,
  output logic [ILEN-1:0] instr,
  input  logic            write_enable,
  input  logic            read_enable,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] write_data,
  input  logic [1:0]      mem_write,
  input  logic [2:0]      size_load,
  output logic [XLEN-1:0] read_data,
  output logic            busy
);

  typedef enum logic [3:0] {
    S_BOOT, S_SEND_READY, S_WAIT_CMD, S_SEND_PC, S_RECV_INSTR, S_RUN,
    S_SEND_ADDR, S_SEND_MW, S_SEND_WDATA, S_SEND_SL, S_RECV_RDATA, S_SEND_NAK
  } state_t;

  // The receive shift register is shared by instruction and load data.
  localparam int         SR_W   = (XLEN > ILEN) ? XLEN : ILEN;
  localparam logic [3:0] X_LAST = 4'(XLEN / 8 - 1);
  localparam logic [3:0] I_LAST = 4'(ILEN / 8 - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   tx_sr_q, tx_sr_d;
  logic [SR_W-1:0]   rx_sr_q, rx_sr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [1:0]        mw_q, mw_d;
  logic [2:0]        sl_q, sl_d;
  logic              is_load_q, is_load_d;
  logic              tx_valid_q, tx_valid_d;
  logic              rx_ready_q, rx_ready_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              cpu_run_q, cpu_run_d;
  logic [ILEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   read_data_q, read_data_d;
  logic              busy_q, busy_d;
  logic              tx_fire_s, rx_fire_s;
  logic [SR_W-1:0]   rx_shift_s;

`ifdef UART_CPU_LINK_TIMEOUT_EN
  localparam int            TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  assign tx_fire_s  = tx_valid_q && tx_ready;
  assign rx_fire_s  = rx_ready_q && rx_valid;
  // New bytes enter at the top so that after N bytes the field sits MSB-aligned, LE order.
  assign rx_shift_s = (rx_sr_q >> 8) | (SR_W'(rx_data) << (SR_W - 8));

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    wdata_d     = wdata_q;
    mw_d        = mw_q;
    sl_d        = sl_q;
    is_load_d   = is_load_q;
    cpu_reset_d = 1'b0;
    cpu_run_d   = 1'b0;
    instr_d     = instr_q;
    read_data_d = read_data_q;
`ifdef UART_CPU_LINK_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif

    case (state_q)
      S_BOOT: begin
        cpu_reset_d = 1'b1;
        state_d     = S_SEND_READY;
      end
      S_WAIT_CMD: begin
        if (rx_fire_s) begin
          case (rx_data)
            8'h01:   state_d = S_BOOT;
            8'h02:   state_d = S_SEND_PC;
            8'h03:   state_d = S_RECV_INSTR;
            default: state_d = S_SEND_NAK;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      S_SEND_PC, S_SEND_ADDR, S_SEND_WDATA: begin
        if (tx_fire_s && cnt_q == X_LAST) begin
          case (state_q)
            S_SEND_ADDR: state_d = is_load_q ? S_SEND_SL : S_SEND_MW;
            default:     state_d = S_SEND_READY;
          endcase
        end else if (tx_fire_s) begin
          cnt_d   = cnt_q + 4'd1;
          tx_sr_d = tx_sr_q >> 8;
        end else begin
          state_d = state_q;
        end
      end
      S_SEND_READY, S_SEND_NAK, S_SEND_MW, S_SEND_SL: begin
        if (tx_fire_s) begin
          case (state_q)
            S_SEND_READY: state_d = S_WAIT_CMD;
            S_SEND_MW:    state_d = S_SEND_WDATA;
            S_SEND_SL:    state_d = S_RECV_RDATA;
            default:      state_d = S_SEND_READY;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      S_RECV_INSTR, S_RECV_RDATA: begin
        if (rx_fire_s) begin
          rx_sr_d = rx_shift_s;
          if (cnt_q == ((state_q == S_RECV_INSTR) ? I_LAST : X_LAST)) begin
            state_d = (state_q == S_RECV_INSTR) ? S_RUN : S_SEND_READY;
            if (state_q == S_RECV_INSTR) begin
              // Whole word lands at once so the CPU never sees a partial instruction.
              instr_d   = rx_shift_s[SR_W-1 -: ILEN];
              cpu_run_d = 1'b1;
            end else begin
              read_data_d = rx_shift_s[SR_W-1 -: XLEN];
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        wdata_d = write_data;
        mw_d    = mem_write;
        sl_d    = size_load;
        // Store wins when the CPU raises both requests.
        if (write_enable) begin
          is_load_d = 1'b0;
          state_d   = S_SEND_ADDR;
        end else if (read_enable) begin
          is_load_d = 1'b1;
          state_d   = S_SEND_ADDR;
        end else begin
          state_d = S_SEND_READY;
        end
      end
      default: state_d = S_BOOT;
    endcase

`ifdef UART_CPU_LINK_TIMEOUT_EN
    // Host-silence counter: only counts while waiting for host bytes, saturates at the limit.
    if (rx_fire_s || !(state_q == S_RECV_INSTR || state_q == S_RECV_RDATA)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_MAX) begin
      state_d = S_SEND_NAK;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
`endif

    // State entry: restart the byte counter and preload the outgoing field.
    if (state_d != state_q) begin
      cnt_d = 4'd0;
      case (state_d)
        S_SEND_READY: tx_sr_d = XLEN'(READY_BYTE);
        S_SEND_NAK:   tx_sr_d = XLEN'(NAK_BYTE);
        S_SEND_PC:    tx_sr_d = pc;
        S_SEND_ADDR:  tx_sr_d = address;  // only entered from RUN, so this latches the request
        S_SEND_MW:    tx_sr_d = XLEN'({6'b0, mw_q});
        S_SEND_WDATA: tx_sr_d = wdata_q;
        S_SEND_SL:    tx_sr_d = XLEN'({5'b0, sl_q});
        default:      tx_sr_d = tx_sr_q;
      endcase
    end else begin
      cnt_d = cnt_d;
    end

    tx_valid_d = (state_d == S_SEND_READY) || (state_d == S_SEND_NAK) ||
                 (state_d == S_SEND_PC)    || (state_d == S_SEND_ADDR) ||
                 (state_d == S_SEND_MW)    || (state_d == S_SEND_WDATA) ||
                 (state_d == S_SEND_SL);
    rx_ready_d = (state_d == S_WAIT_CMD) || (state_d == S_RECV_INSTR) ||
                 (state_d == S_RECV_RDATA);
    busy_d     = (state_d != S_WAIT_CMD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_BOOT;
      cnt_q       <= 4'd0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      wdata_q     <= '0;
      mw_q        <= 2'd0;
      sl_q        <= 3'd0;
      is_load_q   <= 1'b0;
      tx_valid_q  <= 1'b0;
      rx_ready_q  <= 1'b0;
      cpu_reset_q <= 1'b0;
      cpu_run_q   <= 1'b0;
      instr_q     <= '0;
      read_data_q <= '0;
      busy_q      <= 1'b0;
`ifdef UART_CPU_LINK_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      wdata_q     <= wdata_d;
      mw_q        <= mw_d;
      sl_q        <= sl_d;
      is_load_q   <= is_load_d;
      tx_valid_q  <= tx_valid_d;
      rx_ready_q  <= rx_ready_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_run_q   <= cpu_run_d;
      instr_q     <= instr_d;
      read_data_q <= read_data_d;
      busy_q      <= busy_d;
`ifdef UART_CPU_LINK_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign tx_data   = tx_sr_q[7:0];
  assign tx_valid  = tx_valid_q;
  assign rx_ready  = rx_ready_q;
  assign cpu_reset = cpu_reset_q;
  assign cpu_run   = cpu_run_q;
  assign instr     = instr_q;
  assign read_data = read_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cpu_link.sv
// Testbench for uart_cpu_link: directed plus randomized host sessions checked
// against a byte-level reference model of the link protocol.
module tb_uart_cpu_link;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_valid = 1'b0;
  logic            rx_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready = 1'b1;
  logic [XLEN-1:0] pc = '0;
  logic            cpu_reset, cpu_run;
  logic [ILEN-1:0] instr;
  logic            write_enable = 1'b0, read_enable = 1'b0;
  logic [XLEN-1:0] address = '0, write_data = '0;
  logic [1:0]      mem_write = 2'd0;
  logic [2:0]      size_load = 3'd0;
  logic [XLEN-1:0] read_data;
  logic            busy;

  uart_cpu_link #(.XLEN(XLEN), .ILEN(ILEN), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .pc(pc), .cpu_reset(cpu_reset), .cpu_run(cpu_run), .instr(instr),
    .write_enable(write_enable), .read_enable(read_enable),
    .address(address), .write_data(write_data),
    .mem_write(mem_write), .size_load(size_load),
    .read_data(read_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         passed = 0;
  logic [7:0] txq[$];
  logic [7:0] exp_q[$];
  int         run_cnt = 0;
  int         rst_cnt = 0;
  logic       bp_en = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [ILEN-1:0] m_instr = '0;
  logic [XLEN-1:0] m_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Transmitter model: random backpressure, byte capture, hold-stability and pulse counting.
  always @(negedge clk) begin
    bit nr;
    if (!rst_n) begin
      prev_stall <= 1'b0;
      tx_ready   <= 1'b1;
    end else begin
      nr = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (prev_stall) chk("tx_hold", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, prev_data});
      if (tx_valid && nr) txq.push_back(tx_data);
      prev_stall <= tx_valid && !nr;
      prev_data  <= tx_data;
      tx_ready   <= nr;
      if (cpu_run)   run_cnt <= run_cnt + 1;
      if (cpu_reset) rst_cnt <= rst_cnt + 1;
    end
  end

  task automatic exp_push(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[8*i +: 8]);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      int n;
      n = 0;
      while (txq.size() == 0 && n < 3000) begin @(negedge clk); n++; end
      if (txq.size() == 0) begin
        chk({tag, "_tx_timeout"}, 64'(txq.size()), 64'd1);
        exp_q.delete();
      end else begin
        chk(tag, 64'(txq.pop_front()), 64'(exp_q.pop_front()));
      end
    end
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b, output int waited);
    rx_data = b; rx_valid = 1'b1; waited = 0;
    while (rx_ready !== 1'b1 && waited < 3000) begin @(negedge clk); waited++; end
    if (rx_ready !== 1'b1) chk("rx_accept_timeout", 64'(rx_ready), 64'd1);
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic step(input logic [ILEN-1:0] iw, input logic we, input logic re,
                      input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wd,
                      input logic [1:0] mw, input logic [2:0] sl,
                      input logic [XLEN-1:0] rd, input string tag);
    int w;
    int runs0;
    runs0 = run_cnt;
    write_enable = we; read_enable = re; address = addr; write_data = wd;
    mem_write = mw; size_load = sl;
    send_byte(8'h03, w);
    for (int i = 0; i < ILEN / 8; i++) send_byte(iw[8*i +: 8], w);
    chk({tag, "_run_latency"}, 64'(cpu_run), 64'd1);
    chk({tag, "_instr"}, 64'(instr), 64'(iw));
    m_instr = iw;
    if (we) begin
      exp_push(64'(addr), XLEN / 8); exp_push(64'(mw), 1);
      exp_push(64'(wd), XLEN / 8);   exp_push(64'h01, 1);
      drain({tag, "_store"});
    end else if (re) begin
      exp_push(64'(addr), XLEN / 8); exp_push(64'(sl), 1);
      drain({tag, "_load_req"});
      for (int i = 0; i < XLEN / 8; i++) begin
        if (i == XLEN / 8 - 1) chk({tag, "_rdata_held"}, 64'(read_data), 64'(m_rdata));
        send_byte(rd[8*i +: 8], w);
      end
      chk({tag, "_rdata"}, 64'(read_data), 64'(rd));
      m_rdata = rd;
      exp_push(64'h01, 1);
      drain({tag, "_load_done"});
    end else begin
      exp_push(64'h01, 1);
      drain({tag, "_plain"});
    end
    write_enable = 1'b0; read_enable = 1'b0;
    chk({tag, "_run_pulses"}, 64'(run_cnt), 64'(runs0 + 1));
  endtask

  initial begin
    int w;
    int n;
    int r0;
    logic [7:0] c;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_outputs", {50'd0, tx_valid, rx_ready, cpu_reset, cpu_run, busy, tx_data},
        64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_rdata", 64'(read_data), 64'd0);
    rst_n = 1'b1;

    // Boot: single cpu_reset pulse, READY byte, then idle
    exp_push(64'h01, 1);
    drain("boot_ready");
    @(negedge clk);
    chk("boot_rst_pulse", 64'(rst_cnt), 64'd1);
    chk("boot_idle_busy", 64'(busy), 64'd0);
    chk("boot_rx_ready", 64'(rx_ready), 64'd1);
    bp_en = 1'b1;

    // PC readback: directed then random
    pc = 32'h0000_0040;
    send_byte(8'h02, w);
    exp_push(64'(pc), XLEN / 8); exp_push(64'h01, 1);
    drain("pc_dir");
    for (int k = 0; k < 3; k++) begin
      pc = $urandom;
      send_byte(8'h02, w);
      exp_push(64'(pc), XLEN / 8); exp_push(64'h01, 1);
      drain("pc_rand");
    end

    // Directed steps from the plan
    step(32'h0050_0513, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 3'd0, 32'h0, "step_plain");
    step($urandom, 1'b1, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 2'd2, 3'd0, 32'h0, "step_store");
    step($urandom, 1'b0, 1'b1, $urandom, 32'h0, 2'd0, 3'd3, 32'h1234_5678, "step_load");
    step($urandom, 1'b1, 1'b1, $urandom, $urandom, 2'd1, 3'd5, 32'h0, "step_both");

    // Randomized steps
    for (int k = 0; k < 8; k++) begin
      step($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, "step_rand");
    end
    chk("instr_held", 64'(instr), 64'(m_instr));

    // Unknown commands give NAK
    send_byte(8'h7F, w);
    exp_push(64'hEE, 1); exp_push(64'h01, 1);
    drain("nak_7f");
    for (int k = 0; k < 3; k++) begin
      c = 8'($urandom_range(4, 255));
      if (k == 0) c = 8'h00;
      send_byte(c, w);
      exp_push(64'hEE, 1); exp_push(64'h01, 1);
      drain("nak_rand");
    end

    // Mid-session reboot keeps instr and read_data
    r0 = rst_cnt;
    send_byte(8'h01, w);
    exp_push(64'h01, 1);
    drain("reboot_ready");
    chk("reboot_pulse", 64'(rst_cnt), 64'(r0 + 1));
    chk("reboot_instr", 64'(instr), 64'(m_instr));
    chk("reboot_rdata", 64'(read_data), 64'(m_rdata));

    // Byte offered while the link is transmitting stays pending
    pc = $urandom;
    send_byte(8'h02, w);
    send_byte(8'h55, w);
    chk("pending_waited", 64'(w > 0), 64'd1);
    exp_push(64'(pc), XLEN / 8); exp_push(64'h01, 1);
    exp_push(64'hEE, 1); exp_push(64'h01, 1);
    drain("pending_order");

    // Async reset in the middle of a PC transfer
    pc = $urandom;
    send_byte(8'h02, w);
    exp_push(64'(pc), 1);
    drain("abort_first");
    #2 rst_n = 1'b0;
    #1;
    chk("abort_tx_valid", 64'(tx_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_instr", 64'(instr), 64'd0);
    chk("abort_rdata", 64'(read_data), 64'd0);
    @(negedge clk); @(negedge clk);
    txq.delete();
    m_instr = '0; m_rdata = '0;
    r0 = rst_cnt;
    rst_n = 1'b1;
    exp_push(64'h01, 1);
    drain("abort_reboot");
    chk("abort_rst_pulse", 64'(rst_cnt), 64'(r0 + 1));

`ifdef UART_CPU_LINK_TIMEOUT_EN
    // Host goes silent mid-instruction: NAK after the timeout, no step
    r0 = run_cnt;
    send_byte(8'h03, w);
    send_byte(8'($urandom), w);
    send_byte(8'($urandom), w);
    n = 0;
    while (txq.size() == 0 && n < 200) begin
      @(negedge clk); n++;
      if (n == 8) chk("to_busy", 64'(busy), 64'd1);
    end
    chk("to_delay", 64'(n >= 16), 64'd1);
    exp_push(64'hEE, 1); exp_push(64'h01, 1);
    drain("to_nak");
    chk("to_no_run", 64'(run_cnt), 64'(r0));
    chk("to_instr", 64'(instr), 64'(m_instr));
    chk("to_rdata", 64'(read_data), 64'(m_rdata));
`endif

    step(32'h0050_0513, 1'b0, 1'b1, $urandom, 32'h0, 2'd0, 3'd2, $urandom, "step_final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
